// File: rtl/fetch_queue.sv
// fetch_queue: PC-driven ROM fetch into a small FIFO feeding decode over valid/ready
module fetch_queue #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   pcIn,
  output logic                    pcPause,
  output logic                    memEn,
  output logic [ADDR_WIDTH-1:0]   memAddr,
  input  logic [DATA_WIDTH-1:0]   memData,
  input  logic                    flush,
  output logic [DATA_WIDTH-1:0]   instrOut,
  output logic [ADDR_WIDTH-1:0]   pcOut,
  output logic                    instrValid,
  input  logic                    instrReady,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_WIDTH-1:0] pc_mem [DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic inflight_valid;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic push, pop;
  // An outstanding read reserves a slot, so issue never depends on instrReady
  assign memEn = ~rst & ~flush & ((count + CW'(inflight_valid)) < CW'(DEPTH));
  assign pcPause = ~memEn;
  assign memAddr = pcIn;
  assign instrValid = count != '0;
  assign instrOut = instr_mem[rd_ptr];
  assign pcOut = pc_mem[rd_ptr];
  assign push = inflight_valid & ~flush;
  assign pop = instrValid & instrReady & ~flush;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      inflight_valid <= 1'b0;
      inflight_pc <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i] <= '0;
        instr_mem[i] <= '0;
      end
    end else begin
      inflight_valid <= memEn;
      inflight_pc <= pcIn;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
      end else begin
        if (push) begin
          pc_mem[wr_ptr] <= inflight_pc;
          instr_mem[wr_ptr] <= memData;
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage directly downstream of the program counter. Each cycle it takes the current PC, issues a read to a synchronous instruction ROM, and captures the returned word with its PC into a small FIFO. The FIFO feeds the decode stage over a valid/ready handshake. When the FIFO has no room, the block holds the counter through its pause input, and it drops all fetched and in-flight instructions on a branch flush.

## Interface
- ADDR_WIDTH, 6, PC/ROM address width; matches the counter's count width
- DATA_WIDTH, 32, instruction width
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- pcIn  in  ADDR_WIDTH  current PC from counter (zero output delay)
- pcPause  out  1  to counter pause; high = hold PC
- memEn  out  1  ROM read enable
- memAddr  out  ADDR_WIDTH  ROM address, equals pcIn (combinational)
- memData  in  DATA_WIDTH  ROM data, valid the cycle after memEn
- flush  in  1  discard all entries and any in-flight read
- instrOut  out  DATA_WIDTH  head-entry instruction
- pcOut  out  ADDR_WIDTH  head-entry PC
- instrValid  out  1  head entry valid
- instrReady  in  1  decode accepts head entry
- count  out  log2(DEPTH)+1  FIFO occupancy

## Operation
- State:
  - FIFO storage (DEPTH × {pc, instr}) with read/write pointers and count.
  - inflightValid and inflightPc registers.
- Issue rule:
  - memEn = ~rst & ~flush & (count + inflightValid < DEPTH).
  - pcPause = ~memEn.
  - The issue decision uses registered state only. It has no combinational path from instrReady.
- Every cycle with memEn=1 the counter advances, so each PC is issued exactly once.
- At each edge:
  - inflightValid ← memEn.
  - inflightPc ← pcIn.
- Push: inflightValid & ~flush. Writes {inflightPc, memData} at the tail.
- Pop: instrValid & instrReady & ~flush. Advances the head.
- Push and pop in the same cycle are both performed; count is unchanged.
- Overflow is impossible by construction. A push while full is an assertion failure in verification.
- Head outputs:
  - instrValid = (count != 0).
  - instrOut and pcOut show the head entry. They are held stable while instrValid & ~instrReady.
- Flush (one or more cycles):
  - At the edge: count ← 0, pointers ← 0, inflightValid ← 0.
  - The ROM word returning in the cycle after a flush is discarded.
  - The counter performs its own load (load has priority over pause).
  - Fetch resumes from the new PC in the first cycle after flush deasserts.
- Count arithmetic is modulo-free: 0 ≤ count ≤ DEPTH. Pointers wrap modulo DEPTH.

## Timing
- Reset (asynchronous, effective immediately without a clock edge):
  - Registers: count=0, pointers=0, inflightValid=0, inflightPc=0, all storage=0.
  - Outputs during rst: instrValid=0, instrOut=0, pcOut=0, memEn=0, pcPause=1.
- Latency:
  - PC sampled with memEn at cycle N → memData at N+1 → pushed at edge ending N+1 → instrValid/pcOut visible in cycle N+2.
  - Total: 2 cycles.
- Throughput: one instruction per cycle with instrReady held high. count settles at 1 and inflightValid at 1, so no pause occurs.
- Backpressure: pcPause rises the cycle after count + inflightValid reaches DEPTH. It falls the cycle after a pop lowers count.
- Flush: instrValid=0 in the cycle after the flush edge. The first post-flush instruction appears 2 cycles after the new PC is presented.

## Test plan
- Reset release, ROM[a]=0x1000+a, instrReady=1 → first instrValid 2 cycles after first memEn. pcOut=0,1,2,3,… on consecutive cycles with instrOut=0x1000+pcOut; no gaps or duplicates.
- instrReady=0 from reset → exactly 4 reads issued (PC 0–3), count=4, pcPause=1, counter holds at 4. Raise instrReady → pcOut 0,1,2,3,4,5… with no gap or duplicate.
- Queue full (count=4), pulse flush one cycle with counter load 0x20 → count=0 and instrValid=0 next cycle. Next valid entry is pcOut=0x20, instrOut=0x1020; no stale PC 0–4 ever appears.
- Flush in the cycle after issuing PC 7 → ROM data for PC 7 is discarded and never pushed. count stays 0 until the new PC's word arrives.
- count=3, inflightValid=1, instrReady=1 → push and pop in the same cycle, count stays 3. Head advances by one; pcPause stays 1 until count+inflightValid<4.
- Assert rst asynchronously mid-stream (between edges) with count=2 → instrValid=0, count=0, pcPause=1 before the next clock edge. After release, fetch restarts from PC 0.
